cache_ctrl: RTL and testbench

- Sequencing controller for the 16-bit-address, direct-mapped instruction/data cache: 64 lines × 256-bit blocks of 16 × 16-bit words.
- Address split: tag = addr[15:10], index = addr[9:4], word offset = addr[3:0].
- Sits between the CPU request port, the cache array and main memory.
- Owns cache invalidation after reset, lookup, miss refill (block read from memory then fill), write-through writes, and hit/miss statistics.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/sat_counter.sv | 30 +++
 rtl/cache_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller: FSM states,
// address field positions and cache geometry.
package cache_pkg;

  localparam int LINES           = 64;
  localparam int WORDS_PER_BLOCK = 16;

  localparam int OFFSET_LSB = 0;
  localparam int OFFSET_MSB = 3;
  localparam int INDEX_LSB  = 4;
  localparam int INDEX_MSB  = 9;
  localparam int TAG_LSB    = 10;
  localparam int TAG_MSB    = 15;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    LOOKUP,
    MEM_RD,
    FILL,
    REPLAY,
    WR_CACHE,
    MEM_WR,
    RESP
  } cache_state_e;

  // Block-aligned address: offset bits cleared.
  function automatic logic [TAG_MSB:0] block_addr(input logic [TAG_MSB:0] a);
    return {a[TAG_MSB:INDEX_LSB], {(OFFSET_MSB - OFFSET_LSB + 1){1'b0}}};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// Sequencer for a 64-line direct-mapped cache: invalidation sweep after reset,
// lookup, block refill on read miss, write-through writes, hit/miss statistics.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int BLOCK_W = 256,
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  // CPU port: request accepted when cpu_req_valid && cpu_ready; exactly one
  // cpu_resp_valid pulse follows per accepted request. Memory port: mem_req and
  // its address/data stay stable until the single-cycle mem_ack completes it.
  input  logic               cpu_req_valid,
  input  logic               cpu_req_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic               cpu_resp_valid,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cache_inv,
  output logic [INDEX_W-1:0] cache_index,
  output logic               cache_rd,
  output logic               cache_wr,
  output logic               cache_fill,
  output logic [ADDR_W-1:0]  cache_addr,
  output logic [DATA_W-1:0]  cache_wdata,
  output logic [BLOCK_W-1:0] cache_block,
  input  logic               cache_hit,
  input  logic [DATA_W-1:0]  cache_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count,
  output cache_state_e       state_dbg
);

  cache_state_e       state_q, state_d;
  logic [INDEX_W-1:0] sweep_q, sweep_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               hit_inc, miss_inc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= INIT;
      sweep_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      block_q <= block_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    addr_d         = addr_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    block_d        = block_q;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    cpu_ready      = 1'b0;
    cpu_resp_valid = 1'b0;
    cache_inv      = 1'b0;
    cache_rd       = 1'b0;
    cache_wr       = 1'b0;
    cache_fill     = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;

    case (state_q)
      INIT: begin
        // Reset holds the state in INIT, so the sweep strobe is masked while
        // reset is asserted to keep every strobe quiet during reset.
        cache_inv = Reset;
        sweep_d   = sweep_q + INDEX_W'(1);
        if (sweep_q == INDEX_W'(LINES - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req_valid) begin
          addr_d  = cpu_addr;
          we_d    = cpu_req_we;
          wdata_d = cpu_wdata;
          rdata_d = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        cache_rd = 1'b1;
        if (cache_hit) begin
          hit_inc = 1'b1;
          if (we_q) begin
            state_d = WR_CACHE;
          end else begin
            rdata_d = cache_rdata;
            state_d = RESP;
          end
        end else begin
          miss_inc = 1'b1;
          state_d  = we_q ? MEM_WR : MEM_RD;
        end
      end
      MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          block_d = mem_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        cache_fill = 1'b1;
        state_d    = REPLAY;
      end
      REPLAY: begin
        // Re-lookup after refill; statistics already counted this request.
        cache_rd = 1'b1;
        if (cache_hit) begin
          rdata_d = cache_rdata;
          state_d = RESP;
        end else begin
          state_d = MEM_RD;
        end
      end
      WR_CACHE: begin
        cache_wr = 1'b1;
        state_d  = MEM_WR;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  assign cpu_rdata   = rdata_q;
  assign cache_index = sweep_q;
  assign cache_addr  = addr_q;
  assign cache_wdata = wdata_q;
  assign cache_block = block_q;
  assign mem_addr    = (state_q == MEM_WR) ? addr_q : block_addr(addr_q);
  assign mem_wdata   = wdata_q;
  assign state_dbg   = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: models the cache array and main memory around the DUT
// and predicts hits, data and latency from a tag/valid + flat-memory model.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         cpu_req_valid = 1'b0;
  logic         cpu_req_we = 1'b0;
  logic [15:0]  cpu_addr = '0;
  logic [15:0]  cpu_wdata = '0;
  logic         cpu_ready, cpu_resp_valid;
  logic [15:0]  cpu_rdata;
  logic         cache_inv, cache_rd, cache_wr, cache_fill;
  logic [5:0]   cache_index;
  logic [15:0]  cache_addr, cache_wdata;
  logic [255:0] cache_block;
  logic         cache_hit;
  logic [15:0]  cache_rdata;
  logic         mem_req, mem_we;
  logic [15:0]  mem_addr, mem_wdata;
  logic         mem_ack = 1'b0;
  logic [255:0] mem_rdata = '0;
  logic [15:0]  hit_count, miss_count;
  cache_state_e state_dbg;

  // Clock / reset
  always #5 Clk = ~Clk;

  cache_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
    .cache_inv(cache_inv), .cache_index(cache_index), .cache_rd(cache_rd),
    .cache_wr(cache_wr), .cache_fill(cache_fill), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_block(cache_block),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // Cache array environment
  bit           c_valid[64];
  logic [5:0]   c_tag[64];
  logic [255:0] c_line[64];

  always_comb begin
    cache_hit   = c_valid[cache_addr[9:4]] && (c_tag[cache_addr[9:4]] == cache_addr[15:10]);
    cache_rdata = c_line[cache_addr[9:4]][{cache_addr[3:0], 4'b0000} +: 16];
  end

  always @(posedge Clk) begin
    if (cache_inv) c_valid[cache_index] <= 1'b0;
    if (cache_fill) begin
      c_valid[cache_addr[9:4]] <= 1'b1;
      c_tag[cache_addr[9:4]]   <= cache_addr[15:10];
      c_line[cache_addr[9:4]]  <= cache_block;
    end
    if (cache_wr) c_line[cache_addr[9:4]][{cache_addr[3:0], 4'b0000} +: 16] <= cache_wdata;
  end

  // Main memory (environment) and reference model state
  logic [15:0] mem_env[65536];
  logic [15:0] mem_ref[65536];
  bit          ref_valid[64];
  logic [5:0]  ref_tag[64];
  int          exp_hits = 0;
  int          exp_misses = 0;

  // Scoreboard
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sweep(input string tag);
    int errs = 0;
    for (int i = 0; i < 64; i++) begin
      if (cache_inv !== 1'b1 || cache_index !== i[5:0] || cache_rd !== 1'b0 ||
          mem_req !== 1'b0 || cpu_ready !== 1'b0 || cache_fill !== 1'b0) errs++;
      @(negedge Clk);
      mem_ack = 1'b0;
    end
    chk({tag, "_inv_sweep"}, errs, 0);
    chk({tag, "_ready_at_64"}, {31'b0, cpu_ready}, 1);
    chk({tag, "_hits"}, {16'b0, hit_count}, 0);
    chk({tag, "_misses"}, {16'b0, miss_count}, 0);
  endtask

  // Driver: one CPU transaction, acting as memory with ack delay k.
  task automatic do_req(input logic [15:0] a, input logic we, input logic [15:0] wd, input int k);
    logic [5:0]  idx = a[9:4];
    bit          exp_hit;
    int          exp_lat, exp_fill, exp_wr, exp_req_cyc;
    logic [15:0] exp_maddr = we ? a : {a[15:4], 4'h0};
    int n = 0, req_run = -1, req_cyc = 0, fills = 0, wrs = 0, strobe_err = 0, port_err = 0;
    int lat = -1;
    logic [15:0] got_data = '0;
    bit got_resp = 1'b0;

    exp_hit = ref_valid[idx] && (ref_tag[idx] == a[15:10]);
    if (!we) begin
      exp_q.push_back(mem_ref[a]);
      exp_lat  = exp_hit ? 2 : 5 + k;
      exp_fill = exp_hit ? 0 : 1;
      if (!exp_hit) begin
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = a[15:10];
      end
    end else begin
      exp_q.push_back(16'h0000);
      exp_lat    = exp_hit ? 4 + k : 3 + k;
      exp_fill   = 0;
      mem_ref[a] = wd;
    end
    exp_wr      = (we && exp_hit) ? 1 : 0;
    exp_req_cyc = (!we && exp_hit) ? 0 : k + 1;
    if (exp_hit) exp_hits++; else exp_misses++;

    while (cpu_ready !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("ready_before_req", {31'b0, cpu_ready}, 1);

    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_addr      = a;
    cpu_wdata     = wd;
    for (n = 1; n <= 40 && !got_resp; n++) begin
      @(negedge Clk);
      cpu_req_valid = 1'b0;
      cpu_addr      = 16'($urandom);
      cpu_wdata     = 16'($urandom);
      mem_ack       = 1'b0;
      if (int'(cache_inv) + int'(cache_rd) + int'(cache_wr) + int'(cache_fill) > 1) strobe_err++;
      fills += int'(cache_fill);
      wrs   += int'(cache_wr);
      if (mem_req === 1'b1) begin
        req_run++;
        req_cyc++;
        if (mem_we !== we || mem_addr !== exp_maddr || (we && mem_wdata !== wd)) port_err++;
        if (req_run == k) begin
          mem_ack = 1'b1;
          if (we) mem_env[a] = wd;
          else for (int i = 0; i < 16; i++) mem_rdata[16*i +: 16] = mem_env[{a[15:4], i[3:0]}];
        end
      end else begin
        req_run = -1;
        if ($urandom_range(0, 3) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = {8{32'($urandom)}};
        end
      end
      if (cpu_resp_valid === 1'b1) begin
        got_resp = 1'b1;
        lat      = n;
        got_data = cpu_rdata;
      end
    end
    mem_ack = 1'b0;

    chk("resp_seen", {31'b0, got_resp}, 1);
    chk("latency", lat, exp_lat);
    chk("rdata", {16'b0, got_data}, {16'b0, exp_q.pop_front()});
    chk("fill_pulses", fills, exp_fill);
    chk("wr_pulses", wrs, exp_wr);
    chk("mem_req_cycles", req_cyc, exp_req_cyc);
    chk("mem_port", port_err, 0);
    chk("strobe_excl", strobe_err, 0);
    chk("hit_count", {16'b0, hit_count}, exp_hits);
    chk("miss_count", {16'b0, miss_count}, exp_misses);
  endtask

  initial begin : main
    int n;
    for (int i = 0; i < 65536; i++) begin
      mem_env[i] = 16'($urandom);
      mem_ref[i] = mem_env[i];
    end
    for (int i = 0; i < 16; i++) begin
      mem_env[16'h1110 + i] = 16'hA000 + 16'(i);
      mem_ref[16'h1110 + i] = 16'hA000 + 16'(i);
    end

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_inv", {31'b0, cache_inv}, 0);
    chk("rst_ready", {31'b0, cpu_ready}, 0);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_rdata", {16'b0, cpu_rdata}, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);

    // Sweep after release, with a CPU request held that must be ignored
    cpu_req_valid = 1'b1;
    cpu_addr      = 16'h1111;
    Reset         = 1'b1;
    #1;
    check_sweep("init");
    cpu_req_valid = 1'b0;

    // Directed sequence
    do_req(16'h1111, 1'b0, 16'h0000, 3);
    do_req(16'h1111, 1'b0, 16'h0000, 2);
    do_req(16'h0112, 1'b0, 16'h0000, 1);
    do_req(16'h0112, 1'b1, 16'hBEEF, 0);
    do_req(16'h0112, 1'b0, 16'h0000, 0);
    do_req(16'h2345, 1'b1, 16'h1234, 2);
    do_req(16'h2345, 1'b0, 16'h0000, 0);
    do_req(16'h2345, 1'b0, 16'h0000, 4);

    // Randomized traffic over a few conflicting lines
    for (int t = 0; t < 80; t++) begin
      do_req({6'($urandom_range(0, 3)), 6'($urandom_range(16, 19)), 4'($urandom)},
             ($urandom_range(0, 2) == 0), 16'($urandom), $urandom_range(0, 4));
    end

    // Reset while waiting in MEM_RD
    n = 0;
    while (cpu_ready !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_addr      = 16'h7777;
    @(negedge Clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk("mid_reached_mem_rd", {31'b0, mem_req}, 1);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_mem_req", {31'b0, mem_req}, 0);
    chk("mid_rst_inv", {31'b0, cache_inv}, 0);
    chk("mid_rst_ready", {31'b0, cpu_ready}, 0);
    chk("mid_rst_counts", {hit_count, miss_count}, 0);
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge Clk);
    Reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = {8{32'($urandom)}};
    #1;
    check_sweep("rerun");
    do_req(16'h1111, 1'b0, 16'h0000, 1);
    do_req(16'h1111, 1'b0, 16'h0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
